// File: rtl/riscv_csr_pkg.sv
// Shared CSR definitions: address map, operation encodings and funct3 decode
// used by both the CSR unit and the control unit.
package riscv_csr_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned CSR_OP_W   = 2;

  localparam logic [CSR_ADDR_W-1:0] CSR_TOHOST   = 12'h51E;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLE    = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRET  = 12'hC02;
  localparam logic [CSR_ADDR_W-1:0] CSR_INSTRETH = 12'hC82;

  typedef enum logic [CSR_OP_W-1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [2:0] FUNCT3_CSRRW  = 3'b001;
  localparam logic [2:0] FUNCT3_CSRRS  = 3'b010;
  localparam logic [2:0] FUNCT3_CSRRC  = 3'b011;
  localparam logic [2:0] FUNCT3_CSRRWI = 3'b101;
  localparam logic [2:0] FUNCT3_CSRRSI = 3'b110;
  localparam logic [2:0] FUNCT3_CSRRCI = 3'b111;

  // One decoded CSR request as presented by the execute stage.
  typedef struct packed {
    logic                  en;
    csr_op_e               op;
    logic [CSR_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       wdata;
    logic                  src_is_x0;
  } csr_req_t;

  // Register and immediate forms map to the same operation.
  function automatic csr_op_e funct3_to_op(input logic [2:0] funct3);
    csr_op_e op;
    case (funct3)
      FUNCT3_CSRRW, FUNCT3_CSRRWI: op = CSR_OP_RW;
      FUNCT3_CSRRS, FUNCT3_CSRRSI: op = CSR_OP_RS;
      FUNCT3_CSRRC, FUNCT3_CSRRCI: op = CSR_OP_RC;
      default:                     op = CSR_OP_NONE;
    endcase
    return op;
  endfunction

  function automatic logic funct3_is_imm(input logic [2:0] funct3);
    return funct3[2];
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running, enable-gated counter with synchronous clear; wraps at all ones.
module csr_counter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_inc;

  assign count_inc = count + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// CSR execute unit: csrrw/csrrs/csrrc (and immediate forms), the tohost
// register driving the csr port, and the cycle/instret counters.
module csr_unit
  import riscv_csr_pkg::*;
#(
  parameter logic [XLEN-1:0]       RESET_TOHOST = 32'h0000_0000,
  parameter int unsigned           CNT_WIDTH    = 64,
  parameter logic [CSR_ADDR_W-1:0] TOHOST_ADDR  = CSR_TOHOST
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csr_en,
  input  logic [CSR_OP_W-1:0]   csr_op,
  input  logic [CSR_ADDR_W-1:0] csr_addr,
  input  logic [XLEN-1:0]       csr_wdata,
  input  logic                  csr_src_is_x0,
  input  logic                  stall,
  input  logic                  retire,
  output logic [XLEN-1:0]       csr_rdata,
  output logic                  csr_illegal,
  output logic [XLEN-1:0]       csr
);

  csr_req_t             req;
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] instret_cnt;
  logic [XLEN-1:0]      tohost;
  logic [XLEN-1:0]      old_value;
  logic [XLEN-1:0]      new_value;
  logic                 mapped;
  logic                 read_only;
  logic                 we;
  logic                 illegal;
  logic                 tohost_commit;

  assign req = '{
    en:        csr_en,
    op:        csr_op_e'(csr_op),
    addr:      csr_addr,
    wdata:     csr_wdata,
    src_is_x0: csr_src_is_x0
  };

  // Cycle counts every un-reset edge; instret only when a retiring instruction is not stalled.
  csr_counter #(.WIDTH(CNT_WIDTH)) u_cycle (
    .clk   (clk),
    .rst   (rst),
    .en    (1'b1),
    .count (cycle_cnt)
  );

  csr_counter #(.WIDTH(CNT_WIDTH)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .en    (retire & ~stall),
    .count (instret_cnt)
  );

  // Address decode and pre-update read value; high halves are zero-extended for narrow counters.
  always_comb begin
    mapped    = 1'b1;
    read_only = 1'b1;
    old_value = '0;
    case (req.addr)
      TOHOST_ADDR: begin
        read_only = 1'b0;
        old_value = tohost;
      end
      CSR_CYCLE:    old_value = cycle_cnt[XLEN-1:0];
      CSR_CYCLEH:   old_value = XLEN'(cycle_cnt[CNT_WIDTH-1:XLEN]);
      CSR_INSTRET:  old_value = instret_cnt[XLEN-1:0];
      CSR_INSTRETH: old_value = XLEN'(instret_cnt[CNT_WIDTH-1:XLEN]);
      default: begin
        mapped    = 1'b0;
        read_only = 1'b0;
      end
    endcase
  end

  // RS/RC with a zero source are pure reads and never count as writes.
  always_comb begin
    we      = req.en & ((req.op == CSR_OP_RW) | ~req.src_is_x0);
    illegal = req.en & (~mapped | (req.op == CSR_OP_NONE) | (we & read_only));
    case (req.op)
      CSR_OP_RW: new_value = req.wdata;
      CSR_OP_RS: new_value = old_value | req.wdata;
      CSR_OP_RC: new_value = old_value & ~req.wdata;
      default:   new_value = old_value;
    endcase
    tohost_commit = we & ~illegal & ~stall & (req.addr == TOHOST_ADDR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tohost <= RESET_TOHOST;
    end else if (tohost_commit) begin
      tohost <= new_value;
    end
  end

  assign csr_rdata   = req.en ? old_value : '0;
  assign csr_illegal = illegal;
  assign csr         = tohost;

endmodule
